// File: rtl/trivium_pkg.sv
// -----------------------------------------------------------------------------
// trivium_pkg
// Shared definitions for the trivium keystream controller.
//   state_t           : controller session states
//   BYTE_W            : width of keystream / data bytes
//   WARMUP_CYCLES_DEF : nominal number of enabled core cycles before the
//                       core produces its first valid keystream byte
// No ports (package).
// -----------------------------------------------------------------------------
package trivium_pkg;

    localparam int BYTE_W            = 8;
    localparam int WARMUP_CYCLES_DEF = 1152;

    typedef enum logic [2:0] {
        IDLE,
        CORE_RST,
        WARMUP,
        RUN,
        DRAIN,
        ERROR
    } state_t;

endpackage

// File: rtl/trivium_ctrl_ks_fifo.sv
// -----------------------------------------------------------------------------
// ks_fifo
// Small synchronous FIFO holding keystream bytes ahead of the XOR stage.
// The head entry is presented combinationally on rdata (show-ahead).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of all entries (discards contents)
//   push/wdata : write one entry (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   rdata      : head entry
//   count      : number of stored entries (0..DEPTH)
//   full/empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module ks_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy tracking; simultaneous push and pop leave the
    // count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage array needs no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/trivium_ctrl.sv
// -----------------------------------------------------------------------------
// trivium_ctrl
// Session sequencer and encryption front-end for a trivium keystream core.
// Resets and warms the core, buffers keystream bytes in ks_fifo and XORs them
// onto a valid/ready byte stream. The core only advances when the FIFO has
// room, so keystream production follows downstream demand.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, stop           : session control pulses
//   core_rst_n, core_en   : drive the core's reset and enable
//   ks_byte, ks_valid     : keystream from the core
//   din, din_valid/ready  : input byte stream (plaintext or ciphertext)
//   dout, dout_valid/ready: output byte stream (din XOR keystream)
//   busy                  : session active (state != IDLE)
//   warm                  : core warmed up (RUN or DRAIN)
//   err                   : sticky warm-up timeout flag, cleared by start
//   ks_count              : keystream bytes consumed
//
// Build option:
//   TRIVIUM_CTRL_KSCNT_EN : when defined, ks_count counts pops (wraps at 2^32,
//                           cleared on start); otherwise ks_count is tied to 0.
// -----------------------------------------------------------------------------
module trivium_ctrl
    import trivium_pkg::*;
#(
    parameter int FIFO_DEPTH      = 4,
    parameter int WARMUP_CYCLES   = WARMUP_CYCLES_DEF,
    parameter int WARMUP_SLACK    = 16,
    parameter int CORE_RST_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    output logic               core_rst_n,
    output logic               core_en,
    input  logic [BYTE_W-1:0]  ks_byte,
    input  logic               ks_valid,
    input  logic [BYTE_W-1:0]  din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic [BYTE_W-1:0]  dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               busy,
    output logic               warm,
    output logic               err,
    output logic [31:0]        ks_count
);

    localparam int CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int WU_LIMIT = WARMUP_CYCLES + WARMUP_SLACK;
    localparam int WU_W     = $clog2(WU_LIMIT + 1);
    localparam int RC_W     = (CORE_RST_CYCLES > 1) ? $clog2(CORE_RST_CYCLES) : 1;

    state_t            state;
    logic [WU_W-1:0]   wu_cnt;
    logic [RC_W-1:0]   rst_cnt;

    logic [BYTE_W-1:0] fifo_head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_flush;
    logic              push;
    logic              pop;
    logic              start_acc;

    // Session status decoded purely from the registered state.
    assign busy       = (state != IDLE);
    assign warm       = (state == RUN) || (state == DRAIN);
    assign core_rst_n = (state == WARMUP) || (state == RUN) || (state == DRAIN);

    // During warm-up the core free-runs; in RUN it only advances when the
    // FIFO can take the byte it produces on that edge.
    assign core_en = (state == WARMUP) ||
                     ((state == RUN) && (fifo_count < CW'(FIFO_DEPTH)));

    // The core steps on exactly the edges where core_en is high, so a valid
    // byte seen with core_en is consumed right then. The full term keeps a
    // full FIFO safe even if core_en is ever widened.
    assign push = core_en && ks_valid && !fifo_full;

    // dout_ready feeds din_ready directly so a byte can be accepted in the
    // same cycle the previous one leaves, giving one byte per cycle.
    assign din_ready = (state == RUN) && !fifo_empty && (!dout_valid || dout_ready);
    assign pop       = din_valid && din_ready;

    // Keystream left over from an ended or failed session is never reused.
    assign fifo_flush = (state == IDLE) || (state == CORE_RST) || (state == ERROR);

    assign start_acc = start && ((state == IDLE) || (state == ERROR));

    ks_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_ks_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (fifo_flush),
        .push  (push),
        .wdata (ks_byte),
        .pop   (pop),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Session FSM. start is only honoured from IDLE/ERROR and stop only
    // elsewhere, which makes start win in IDLE/ERROR and stop win otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            err     <= 1'b0;
            wu_cnt  <= '0;
            rst_cnt <= '0;
        end else begin
            case (state)
                IDLE, ERROR: begin
                    if (start_acc) begin
                        state   <= CORE_RST;
                        rst_cnt <= '0;
                        err     <= 1'b0;
                    end
                end
                CORE_RST: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (rst_cnt == RC_W'(CORE_RST_CYCLES - 1)) begin
                        state  <= WARMUP;
                        wu_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + RC_W'(1);
                    end
                end
                WARMUP: begin
                    // wu_cnt holds the number of completed warm-up cycles, so
                    // the timeout fires at the end of cycle WU_LIMIT.
                    if (stop) begin
                        state <= IDLE;
                    end else if (ks_valid) begin
                        state <= RUN;
                    end else if (wu_cnt == WU_W'(WU_LIMIT - 1)) begin
                        state <= ERROR;
                        err   <= 1'b1;
                    end else begin
                        wu_cnt <= wu_cnt + WU_W'(1);
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!dout_valid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // XOR output register: holds dout until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (pop) begin
            dout       <= din ^ fifo_head;
            dout_valid <= 1'b1;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

`ifdef TRIVIUM_CTRL_KSCNT_EN
    logic [31:0] ks_cnt_q;

    // Counts keystream bytes consumed in the current session.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ks_cnt_q <= '0;
        end else if (start_acc) begin
            ks_cnt_q <= '0;
        end else if (pop) begin
            ks_cnt_q <= ks_cnt_q + 32'd1;
        end
    end

    assign ks_count = ks_cnt_q;
`else
    assign ks_count = '0;
`endif

endmodule

// File: tb/tb_trivium_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trivium_ctrl
// Directed testbench for trivium_ctrl. A behavioural core model produces
// keystream byte k = ks_fn(k) once it has seen 1152 enabled cycles since its
// reset, and advances only on enabled edges.
// -----------------------------------------------------------------------------
module tb_trivium_ctrl;

    localparam int CORE_WARMUP = 1152;
`ifdef TRIVIUM_CTRL_KSCNT_EN
    localparam bit KSCNT = 1'b1;
`else
    localparam bit KSCNT = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        core_rst_n;
    logic        core_en;
    logic [7:0]  ks_byte;
    logic        ks_valid;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        busy;
    logic        warm;
    logic        err;
    logic [31:0] ks_count;

    int checks;
    int failures;
    int en_cnt;
    int push_total;
    int pop_total;
    logic core_mute;

    int         n;
    int         sent;
    int         rcv;
    int         occ;
    logic       tog;
    logic       saw_full;
    logic [7:0] got [8];

    trivium_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .core_rst_n (core_rst_n),
        .core_en    (core_en),
        .ks_byte    (ks_byte),
        .ks_valid   (ks_valid),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .warm       (warm),
        .err        (err),
        .ks_count   (ks_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference keystream sequence.
    function automatic logic [7:0] ks_fn(input int k);
        logic [7:0] a;
        logic [7:0] b;
        a = 8'(k * 37 + 29);
        b = 8'(k * 5);
        return a ^ {b[3:0], b[7:4]};
    endfunction

    // Core model: counts enabled cycles since its own reset.
    always @(posedge clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            en_cnt <= 0;
        end else if (core_en) begin
            en_cnt <= en_cnt + 1;
        end
    end

    assign ks_valid = core_rst_n && !core_mute && (en_cnt >= CORE_WARMUP);
    assign ks_byte  = ks_valid ? ks_fn(en_cnt - CORE_WARMUP) : 8'h00;

    // Occupancy bookkeeping from observed handshakes.
    always @(posedge clk) begin
        if (core_en && ks_valid) push_total <= push_total + 1;
        if (din_valid && din_ready) pop_total <= pop_total + 1;
    end

    // One cycle: drive inputs at the falling edge, let them settle.
    task automatic applyStimulus(input logic s, input logic p, input logic dv,
                                 input logic [7:0] d, input logic dr);
        @(negedge clk);
        start      = s;
        stop       = p;
        din_valid  = dv;
        din        = d;
        dout_ready = dr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_core_rst_n"}, 32'(core_rst_n), 0);
        checkOutput({tag, "_core_en"},    32'(core_en),    0);
        checkOutput({tag, "_din_ready"},  32'(din_ready),  0);
        checkOutput({tag, "_dout"},       32'(dout),       0);
        checkOutput({tag, "_dout_valid"}, 32'(dout_valid), 0);
        checkOutput({tag, "_busy"},       32'(busy),       0);
        checkOutput({tag, "_warm"},       32'(warm),       0);
        checkOutput({tag, "_err"},        32'(err),        0);
        checkOutput({tag, "_ks_count"},   ks_count,        0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        din_valid  = 1'b0;
        din        = 8'h00;
        dout_ready = 1'b0;
        core_mute  = 1'b0;

        // Reset state
        #12;
        checkReset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("idle_busy", 32'(busy), 0);

        // start and stop together from IDLE: session starts, 2 reset cycles
        applyStimulus(1, 1, 0, 8'h00, 0);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("c1_busy",       32'(busy),       1);
        checkOutput("c1_core_rst_n", 32'(core_rst_n), 0);
        checkOutput("c1_core_en",    32'(core_en),    0);
        checkOutput("c1_err",        32'(err),        0);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("c2_core_rst_n", 32'(core_rst_n), 0);
        checkOutput("c2_busy",       32'(busy),       1);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("c3_core_rst_n", 32'(core_rst_n), 1);
        checkOutput("c3_core_en",    32'(core_en),    1);
        checkOutput("c3_warm",       32'(warm),       0);

        // Warm-up: 1153 cycles with warm low (byte 0 arrives in the 1153rd)
        n = 1;
        for (int i = 0; i < 1400; i++) begin
            applyStimulus(0, 0, 0, 8'h00, 1);
            if (warm) break;
            n++;
        end
        checkOutput("warmup_len", n, 1153);
        checkOutput("warm_up",    32'(warm), 1);

        // Test 1: din = 0x00 x8 at full throughput -> raw keystream 0..7
        sent = 0;
        rcv  = 0;
        for (int i = 0; i < 40 && rcv < 8; i++) begin
            applyStimulus(0, 0, (sent < 8), 8'h00, 1);
            if (dout_valid) begin
                got[rcv] = dout;
                rcv++;
            end
            if (din_valid && din_ready) sent++;
        end
        checkOutput("t1_count", rcv, 8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t1_dout%0d", i), 32'(got[i]), 32'(ks_fn(i)));
        end
        checkOutput("t1_ks_count", ks_count, KSCNT ? 32'd8 : 32'd0);

        // Test 2: din = 0xA5 with dout_ready toggling; keystream 8..15
        sent     = 0;
        rcv      = 0;
        tog      = 1'b1;
        saw_full = 1'b0;
        for (int i = 0; i < 80 && rcv < 8; i++) begin
            applyStimulus(0, 0, (sent < 8), 8'hA5, tog);
            occ = push_total - pop_total;
            if (occ == 4) saw_full = 1'b1;
            checkOutput("t2_core_en", 32'(core_en), 32'(occ < 4));
            if (dout_valid && dout_ready) begin
                got[rcv] = dout;
                rcv++;
            end
            if (din_valid && din_ready) sent++;
            tog = !tog;
        end
        checkOutput("t2_count",     rcv, 8);
        checkOutput("t2_saw_full",  32'(saw_full), 1);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t2_xor%0d", i), 32'(got[i] ^ ks_fn(8 + i)), 32'h A5);
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 0, 8'h00, 1);
        end

        // Test 4: stop with a byte pending and dout_ready low -> DRAIN holds
        applyStimulus(0, 0, 1, 8'h5A, 0);
        checkOutput("t4_din_ready", 32'(din_ready), 1);
        applyStimulus(0, 1, 0, 8'h00, 0);
        checkOutput("t4_dout_valid", 32'(dout_valid), 1);
        checkOutput("t4_dout",       32'(dout), 32'(8'h5A ^ ks_fn(16)));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 8'h00, 0);
            checkOutput("drain_busy",       32'(busy),       1);
            checkOutput("drain_warm",       32'(warm),       1);
            checkOutput("drain_core_en",    32'(core_en),    0);
            checkOutput("drain_din_ready",  32'(din_ready),  0);
            checkOutput("drain_dout_valid", 32'(dout_valid), 1);
            checkOutput("drain_dout",       32'(dout), 32'(8'h5A ^ ks_fn(16)));
        end
        applyStimulus(0, 0, 0, 8'h00, 1);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("t4_dv_clear", 32'(dout_valid), 0);
        checkOutput("t4_still_busy", 32'(busy), 1);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("t4_idle_busy",  32'(busy), 0);
        checkOutput("t4_idle_warm",  32'(warm), 0);
        checkOutput("t4_idle_crst",  32'(core_rst_n), 0);
        checkOutput("t4_ks_count",   ks_count, KSCNT ? 32'd17 : 32'd0);

        // Test 5: reset mid-RUN with a byte pending
        applyStimulus(1, 0, 0, 8'h00, 0);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("s2_ks_count_clr", ks_count, 0);
        checkOutput("s2_busy", 32'(busy), 1);
        for (int i = 0; i < 1400; i++) begin
            applyStimulus(0, 0, 0, 8'h00, 0);
            if (warm) break;
        end
        checkOutput("s2_warm", 32'(warm), 1);
        applyStimulus(0, 0, 1, 8'h33, 0);
        checkOutput("s2_din_ready", 32'(din_ready), 1);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("s2_dout_valid", 32'(dout_valid), 1);
        checkOutput("s2_dout",       32'(dout), 32'(8'h33 ^ ks_fn(0)));
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Restart: full re-warm, first output uses keystream byte 0 again
        applyStimulus(1, 0, 0, 8'h00, 0);
        n = 0;
        for (int i = 0; i < 1400; i++) begin
            applyStimulus(0, 0, 0, 8'h00, 0);
            if (warm) break;
            n++;
        end
        checkOutput("s3_rewarm_len", n, 1155);
        applyStimulus(0, 0, 1, 8'h11, 1);
        checkOutput("s3_din_ready", 32'(din_ready), 1);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("s3_dout_valid", 32'(dout_valid), 1);
        checkOutput("s3_dout",       32'(dout), 32'(8'h11 ^ ks_fn(0)));

        // Test 3: core never valid -> timeout after 1168 warm-up cycles
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        core_mute = 1'b1;
        applyStimulus(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0, 8'h00, 0);
            if (core_rst_n) break;
        end
        checkOutput("t3_in_warmup", 32'(core_rst_n), 1);
        n = 0;
        for (int i = 0; i < 1400; i++) begin
            if (!core_en) break;
            n++;
            applyStimulus(0, 0, 0, 8'h00, 0);
        end
        checkOutput("t3_timeout_len", n, 1168);
        checkOutput("t3_err",        32'(err),        1);
        checkOutput("t3_core_rst_n", 32'(core_rst_n), 0);
        checkOutput("t3_core_en",    32'(core_en),    0);
        checkOutput("t3_busy",       32'(busy),       1);
        checkOutput("t3_warm",       32'(warm),       0);
        applyStimulus(0, 1, 0, 8'h00, 0);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("t3_stop_ignored_err",  32'(err),  1);
        checkOutput("t3_stop_ignored_busy", 32'(busy), 1);
        applyStimulus(1, 0, 0, 8'h00, 0);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("t3_err_cleared", 32'(err),        0);
        checkOutput("t3_restart_rst", 32'(core_rst_n), 0);
        checkOutput("t3_restart_busy", 32'(busy),      1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
